// File: rtl/uart_pixel_rx.sv
// uart_pixel_rx: UART 8N1 receiver that assembles RGB565 pixels (high byte first),
// tags start-of-frame and buffers them in a fall-through FIFO behind a valid/ready stream.
module uart_pixel_rx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = 12800,
  parameter int IDLE_BITS    = 20
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ser_rx,
  output logic [15:0]                   pix_data,
  output logic                          pix_sof,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          frame_done
);
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int IDLE_LIM = IDLE_BITS * DIV;
  localparam int CW       = $clog2(DIV + 1);
  localparam int IW       = $clog2(IDLE_LIM + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int XW       = $clog2(FRAME_PIXELS + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic [IW-1:0] r_idle;
  logic          r_phase;
  logic [7:0]    r_hi;
  logic [XW-1:0] r_idx;
  logic          r_push;
  logic [16:0]   r_push_d;
  logic [16:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_level;

  logic          w_tick, w_half, w_pop, w_full, w_wr, w_last;
  logic [AW-1:0] w_head_ix;
  logic [16:0]   w_head;

  assign w_tick    = r_cnt == CW'(DIV - 1);
  assign w_half    = r_cnt == CW'(DIV / 2 - 1);
  assign w_last    = r_idx == XW'(FRAME_PIXELS - 1);
  assign w_pop     = (r_level != '0) && pix_ready;
  assign w_full    = r_level == (AW+1)'(FIFO_DEPTH);
  assign w_wr      = r_push && (!w_full || w_pop);
  // when empty, show the most recently popped entry so pix_data holds its last value
  assign w_head_ix = (r_level == '0) ? r_rp - 1'b1 : r_rp;
  assign w_head    = r_mem[w_head_ix];
  assign pix_data  = w_head[15:0];
  assign pix_sof   = w_head[16];
  assign pix_valid = r_level != '0;
  assign fifo_level = r_level;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_sh       <= '0;
      r_idle     <= '0;
      r_phase    <= 1'b0;
      r_hi       <= '0;
      r_idx      <= '0;
      r_push     <= 1'b0;
      r_push_d   <= '0;
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_rx_s1    <= ser_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_push     <= 1'b0;
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
      r_cnt      <= r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (r_rx_prev && !r_rx_s2) begin
            r_state <= S_START;
            r_idle  <= '0;
          end else if (r_idle != IW'(IDLE_LIM)) begin
            r_idle <= r_idle + 1'b1;
            if (r_idle == IW'(IDLE_LIM - 1)) begin
              r_phase <= 1'b0;
              r_idx   <= '0;
            end
          end
        end
        S_START: if (w_half) begin
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= r_rx_s2 ? S_IDLE : S_DATA;
        end
        S_DATA: if (w_tick) begin
          r_cnt   <= '0;
          r_sh    <= {r_rx_s2, r_sh[7:1]};
          r_bit   <= r_bit + 1'b1;
          r_state <= (r_bit == 3'd7) ? S_STOP : S_DATA;
        end
        S_STOP: if (w_tick) begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
          if (!r_rx_s2) begin
            frame_err <= 1'b1;
            r_phase   <= 1'b0;
          end else if (!r_phase) begin
            r_hi    <= r_sh;
            r_phase <= 1'b1;
          end else begin
            r_phase    <= 1'b0;
            r_push     <= 1'b1;
            r_push_d   <= {r_idx == '0, r_hi, r_sh};
            frame_done <= w_last;
            r_idx      <= w_last ? '0 : r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_level  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= r_push_d;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_level  <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      overflow <= overflow | (r_push && !w_wr);
    end
  end
endmodule
